// File: rtl/cf_ss_422_frame_ctrl.sv
// rtl/cf_ss_422_frame_ctrl.sv - 4:2:2 frame format qualifier and upsampler sequencing controller
module cf_ss_422_frame_ctrl #(
   parameter int HCNT_WIDTH  = 12,
   parameter int VCNT_WIDTH  = 12,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  s422_vs,
   input  logic                  s422_hs,
   input  logic                  s422_de,
   input  logic                  cfg_enable,
   input  logic                  cfg_cr_first,
   input  logic                  err_clr,
   output logic                  Cr_Cb_sel_init,
   output logic                  conv_enable,
   output logic                  locked,
   output logic [HCNT_WIDTH-1:0] active_width,
   output logic [VCNT_WIDTH-1:0] active_height,
   output logic                  err_odd_width,
   output logic                  err_fmt_change
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VS, S_MEASURE, S_CHECK, S_LOCKED
   } state_t;

   localparam logic [HCNT_WIDTH-1:0] H_MAX    = '1;
   localparam logic [HCNT_WIDTH-1:0] H_ONE    = HCNT_WIDTH'(1);
   localparam logic [VCNT_WIDTH-1:0] V_MAX    = '1;
   localparam logic [VCNT_WIDTH-1:0] V_ONE    = VCNT_WIDTH'(1);
   localparam logic [3:0]            LOCK_CNT = 4'(LOCK_FRAMES);

   state_t                state_q, state_d;
   logic                  vs_q, vs_d, de_q, de_d;
   logic [HCNT_WIDTH-1:0] hcnt_q, hcnt_d, line_w_q, line_w_d, ref_w_q, ref_w_d, aw_q, aw_d;
   logic [VCNT_WIDTH-1:0] vcnt_q, vcnt_d, ref_h_q, ref_h_d, ah_q, ah_d;
   logic                  bad_q, bad_d;
   logic [3:0]            match_q, match_d;
   logic                  locked_q, locked_d, conv_q, conv_d;
   logic                  err_odd_q, err_odd_d, err_fmt_q, err_fmt_d, cr_q, cr_d;

   logic                  vs_rise, line_end, run, first_line, w_odd, w_diff;
   logic                  frame_bad, frame_eq, fmt_set;
   logic [HCNT_WIDTH-1:0] frame_w;
   logic [VCNT_WIDTH-1:0] frame_h;
   logic [3:0]            match_inc;
   logic                  unused_hs;

   assign unused_hs  = s422_hs;
   assign vs_rise    = s422_vs & ~vs_q;
   assign line_end   = de_q & ~s422_de;
   assign run        = cfg_enable & (state_q != S_IDLE);
   assign first_line = (vcnt_q == '0);
   assign w_odd      = line_end & hcnt_q[0];
   assign w_diff     = line_end & ~first_line & (hcnt_q != line_w_q);

   // A line ending on the vs_rise edge still belongs to the frame that is closing.
   assign frame_h   = (line_end && vcnt_q != V_MAX) ? vcnt_q + V_ONE : vcnt_q;
   assign frame_w   = (line_end && first_line) ? hcnt_q : line_w_q;
   assign frame_bad = bad_q | w_odd | w_diff | (frame_h == '0);
   assign frame_eq  = (frame_w == ref_w_q) && (frame_h == ref_h_q);
   assign match_inc = match_q + 4'd1;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!cfg_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_WAIT_VS;
            S_WAIT_VS: if (vs_rise) state_d = S_MEASURE;
            S_MEASURE: if (vs_rise && !frame_bad) state_d = S_CHECK;
            S_CHECK: begin
               if (vs_rise) begin
                  if (frame_bad)                               state_d = S_MEASURE;
                  else if (frame_eq && match_inc == LOCK_CNT)  state_d = S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (vs_rise) begin
                  if (frame_bad)      state_d = S_MEASURE;
                  else if (!frame_eq) state_d = S_CHECK;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      vs_d     = s422_vs;
      de_d     = s422_de;
      hcnt_d   = hcnt_q;
      vcnt_d   = vcnt_q;
      line_w_d = line_w_q;
      bad_d    = bad_q;
      ref_w_d  = ref_w_q;
      ref_h_d  = ref_h_q;
      match_d  = match_q;
      aw_d     = aw_q;
      ah_d     = ah_q;
      cr_d     = cr_q;
      fmt_set  = 1'b0;

      if (!run) begin
         hcnt_d  = '0;
         vcnt_d  = '0;
         bad_d   = 1'b0;
         match_d = '0;
      end else begin
         if (s422_de && hcnt_q != H_MAX) hcnt_d = hcnt_q + H_ONE;
         if (line_end) begin
            hcnt_d = '0;
            if (vcnt_q != V_MAX) vcnt_d = vcnt_q + V_ONE;
            if (first_line)      line_w_d = hcnt_q;
            if (w_odd || w_diff) bad_d = 1'b1;
         end
         if (vs_rise) begin
            vcnt_d = '0;
            bad_d  = 1'b0;
            case (state_q)
               S_MEASURE: begin
                  if (!frame_bad) begin
                     ref_w_d = frame_w;
                     ref_h_d = frame_h;
                     match_d = '0;
                  end
               end
               S_CHECK: begin
                  if (!frame_bad && frame_eq) begin
                     match_d = match_inc;
                     if (match_inc == LOCK_CNT) begin
                        aw_d = ref_w_q;
                        ah_d = ref_h_q;
                     end
                  end else if (!frame_bad) begin
                     ref_w_d = frame_w;
                     ref_h_d = frame_h;
                     match_d = '0;
                  end
               end
               S_LOCKED: begin
                  fmt_set = frame_bad | ~frame_eq;
                  if (!frame_bad && !frame_eq) begin
                     ref_w_d = frame_w;
                     ref_h_d = frame_h;
                     match_d = '0;
                  end
               end
               default: ;
            endcase
         end
      end

      // Chroma phase only moves at a clean frame boundary (or freely while idle).
      if ((vs_rise && !s422_de) || state_q == S_IDLE) cr_d = cfg_cr_first;

      locked_d  = (state_d == S_LOCKED);
      conv_d    = (state_d == S_LOCKED);
      err_odd_d = (err_odd_q & ~err_clr) | (run & w_odd);
      err_fmt_d = (err_fmt_q & ~err_clr) | fmt_set;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vs_q      <= 1'b0;
         de_q      <= 1'b0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         line_w_q  <= '0;
         bad_q     <= 1'b0;
         ref_w_q   <= '0;
         ref_h_q   <= '0;
         match_q   <= '0;
         aw_q      <= '0;
         ah_q      <= '0;
         locked_q  <= 1'b0;
         conv_q    <= 1'b0;
         err_odd_q <= 1'b0;
         err_fmt_q <= 1'b0;
         cr_q      <= 1'b0;
      end else begin
         vs_q      <= vs_d;
         de_q      <= de_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         line_w_q  <= line_w_d;
         bad_q     <= bad_d;
         ref_w_q   <= ref_w_d;
         ref_h_q   <= ref_h_d;
         match_q   <= match_d;
         aw_q      <= aw_d;
         ah_q      <= ah_d;
         locked_q  <= locked_d;
         conv_q    <= conv_d;
         err_odd_q <= err_odd_d;
         err_fmt_q <= err_fmt_d;
         cr_q      <= cr_d;
      end
   end

   assign Cr_Cb_sel_init = cr_q;
   assign conv_enable    = conv_q;
   assign locked         = locked_q;
   assign active_width   = aw_q;
   assign active_height  = ah_q;
   assign err_odd_width  = err_odd_q;
   assign err_fmt_change = err_fmt_q;

endmodule
